// File: rtl/b4sreg_pkg.sv
// Shared defaults and the word type for the b4sreg word-wide shift register.
package b4sreg_pkg;

   localparam int B4SREG_WIDTH = 4;
   localparam int B4SREG_DEPTH = 4;

   typedef logic [B4SREG_WIDTH-1:0] word_t;

endpackage : b4sreg_pkg

// File: rtl/b4sreg_stage.sv
// One WIDTH-bit pipeline stage: sync active-high reset, load on enable, hold otherwise.
// Latency one enabled edge; no backpressure, the enable alone gates movement.
module b4sreg_stage
   import b4sreg_pkg::*;
#(
   parameter int WIDTH = B4SREG_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (en_i) begin
         q_d = d_i;
      end
   end

   // Reset wins over enable so a flush always empties the stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : b4sreg_stage

// File: rtl/b4sreg.sv
// Word-wide serial shift register of DEPTH stages; Q_out is the last stage, DEPTH enabled edges after D.
// No backpressure: en=0 freezes every stage, rst flushes all in-flight words.
module b4sreg
   import b4sreg_pkg::*;
#(
   parameter int WIDTH = B4SREG_WIDTH,
   parameter int DEPTH = B4SREG_DEPTH
) (
   input  logic [WIDTH-1:0] D,
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] Q_out
);

   logic [WIDTH-1:0] stage_dat [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] stage_in;

      if (i == 0) begin : g_head
         assign stage_in = D;
      end else begin : g_link
         assign stage_in = stage_dat[i-1];
      end

      b4sreg_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .en_i (en),
         .d_i  (stage_in),
         .q_o  (stage_dat[i])
      );
   end

   // Output is taken straight from the last register, so D/en never reach Q_out combinationally.
   assign Q_out = stage_dat[DEPTH-1];

endmodule : b4sreg

// File: tb/tb_b4sreg.sv
// Directed bench for b4sreg: default DEPTH=4 instance plus a DEPTH=1 instance on the same stimulus.
module tb_b4sreg;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] D;
   logic [3:0] Q_out;
   logic [3:0] q1_out;

   int checks;
   int failures;

   b4sreg #(.WIDTH(4), .DEPTH(4)) dut (
      .D     (D),
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .Q_out (Q_out)
   );

   b4sreg #(.WIDTH(4), .DEPTH(1)) dut1 (
      .D     (D),
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .Q_out (q1_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
   task automatic step(input logic r, input logic e, input logic [3:0] d);
      rst = r;
      en  = e;
      D   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      en  = 1'b0;
      D   = 4'd0;

      // Reset
      step(1'b1, 1'b0, 4'd0);
      check("reset_q", Q_out, 4'd0);
      check("reset_q1", q1_out, 4'd0);
      step(1'b1, 1'b1, 4'd7);
      check("reset_hold_q", Q_out, 4'd0);

      // Fill and latency
      step(1'b0, 1'b1, 4'd9);
      check("fill_e1", Q_out, 4'd0);
      check("fill_e1_d1", q1_out, 4'd9);
      step(1'b0, 1'b1, 4'd9);
      check("fill_e2", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd9);
      check("fill_e3", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd9);
      check("fill_e4", Q_out, 4'd9);

      // Hold: one word loaded, then 20 disabled edges
      step(1'b1, 1'b0, 4'd0);
      check("hold_reset", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd9);
      check("hold_load", Q_out, 4'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 4'd5);
         check("hold_idle", Q_out, 4'd0);
      end
      check("hold_idle_d1", q1_out, 4'd9);
      step(1'b0, 1'b1, 4'd0);
      check("hold_re1", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd0);
      check("hold_re2", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd0);
      check("hold_re3", Q_out, 4'd9);
      step(1'b0, 1'b1, 4'd0);
      check("hold_re4", Q_out, 4'd0);

      // Reset priority over en/D with a full pipe
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'd15);
      end
      check("prio_full", Q_out, 4'd15);
      step(1'b1, 1'b1, 4'd15);
      check("prio_rst", Q_out, 4'd0);
      check("prio_rst_d1", q1_out, 4'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 4'd15);
         check("prio_rst_more", Q_out, 4'd0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'd0);
         check("prio_cleared", Q_out, 4'd0);
      end

      // Sequence ordering
      step(1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 4'd1);
      check("seq_e1", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd2);
      check("seq_e2", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd3);
      check("seq_e3", Q_out, 4'd0);
      step(1'b0, 1'b1, 4'd4);
      check("seq_e4", Q_out, 4'd1);
      step(1'b0, 1'b1, 4'd5);
      check("seq_e5", Q_out, 4'd2);
      step(1'b0, 1'b1, 4'd6);
      check("seq_e6", Q_out, 4'd3);
      check("seq_e6_d1", q1_out, 4'd6);
      step(1'b0, 1'b0, 4'd8);
      check("seq_hold", Q_out, 4'd3);

      // Reset mid-stream: pipe holds 6,5,4,3 from stage 0 to 3
      step(1'b0, 1'b1, 4'd15);
      check("mid_load1", Q_out, 4'd4);
      step(1'b0, 1'b1, 4'd15);
      check("mid_load2", Q_out, 4'd5);
      step(1'b1, 1'b0, 4'd15);
      check("mid_rst", Q_out, 4'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'd0);
         check("mid_drain", Q_out, 4'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_b4sreg
